// File: rtl/nvram_ioctl_bridge.sv
// Bridges data_io download/upload onto a RAM port shared with the game CPU.
// Downloads commit held bytes into RAM; uploads fetch the addressed byte into ioctl_din.
module nvram_ioctl_bridge #(
  parameter logic [7:0] INDEX = 8'd4,
  parameter int         AW    = 10,
  parameter int         SIZE  = 1024
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic          ioctl_upl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  input  logic          cpu_ram_busy,
  output logic          pause_req,
  output logic          busy,
  output logic          lost
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_DATA} state_t;

  state_t        state, state_nx;
  logic          sel, act_dl, act_ul, in_range, ul_req, slot;
  logic [AW-1:0] addr_h;
  logic [7:0]    data_h;
  logic [24:0]   last_addr;
  logic          ul_prev;

  // Download wins when both directions are requested at once.
  assign sel      = (ioctl_index == INDEX);
  assign act_dl   = ioctl_downl & sel;
  assign act_ul   = ioctl_upl & sel & ~act_dl;
  assign in_range = (ioctl_addr < 25'(SIZE));
  assign ul_req   = act_ul & (~ul_prev | (ioctl_addr != last_addr));
  // A strobe is only allowed when the CPU leaves the port free and we are not in reset.
  assign slot     = ~reset & ~cpu_ram_busy;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx  = state;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (act_dl & ioctl_wr & in_range)
          state_nx = WR_WAIT;
        else if (ul_req & in_range)
          state_nx = RD_WAIT;
      end
      WR_WAIT: begin
        if (slot) begin
          ram_cs    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = addr_h;
          ram_wdata = data_h;
          state_nx  = IDLE;
        end
      end
      RD_WAIT: begin
        if (slot) begin
          ram_cs   = 1'b1;
          ram_addr = addr_h;
          state_nx = RD_DATA;
        end
      end
      RD_DATA: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      addr_h    <= '0;
      data_h    <= '0;
      ioctl_din <= '0;
      pause_req <= 1'b0;
      lost      <= 1'b0;
      last_addr <= '0;
      ul_prev   <= 1'b0;
    end else begin
      state   <= state_nx;
      ul_prev <= act_ul;

      if (act_dl | act_ul)
        pause_req <= 1'b1;
      else if (state == IDLE)
        pause_req <= 1'b0;

      if (state == IDLE) begin
        if (act_dl & ioctl_wr) begin
          if (in_range) begin
            addr_h <= ioctl_addr[AW-1:0];
            data_h <= ioctl_dout;
          end
        end else if (ul_req) begin
          last_addr <= ioctl_addr;
          if (in_range)
            addr_h <= ioctl_addr[AW-1:0];
          else
            ioctl_din <= 8'h00;
        end
      end else if (act_dl & ioctl_wr & in_range) begin
        // Only one byte can be held; a second one while busy is dropped.
        lost <= 1'b1;
      end

      if (state == RD_DATA)
        ioctl_din <= ram_rdata;
    end
  end

endmodule
